noc_output_arbiter: RTL and testbench

NOC_OUTPUT_ARBITER -- requirements
Module: noc_output_arbiter

---
 rtl/noc_output_arbiter.sv | 111 +++++++++++
 tb/tb_noc_output_arbiter.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/noc_output_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : noc_output_arbiter
// Description : Router output port. Round-robin arbitration into two
//               single-entry VC buffers, driven onto the link by phase.
// Revision    : 1.0 - initial release
// ============================================================================
module noc_output_arbiter #(
  parameter int NREQ = 5,
  parameter int DW   = 64
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 polarity,
  input  logic [NREQ-1:0]      req,
  input  logic [NREQ*DW-1:0]   data_in,
  output logic [NREQ-1:0]      gnt,
  input  logic                 ri,
  output logic                 so,
  output logic [DW-1:0]        dout,   // link packet data ("do" is a reserved word)
  output logic [15:0]          pkt_count
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [1:0]          full_q, full_d;
  logic [DW-1:0]       buf_q [2];
  logic [DW-1:0]       buf_d [2];
  logic [PW-1:0]       ptr_q [2];
  logic [PW-1:0]       ptr_d [2];
  logic [15:0]         cnt_q, cnt_d;

  logic [DW-1:0]       data_slice [NREQ];
  logic [NREQ-1:0]     elig;
  logic                grant_valid;
  logic [PW-1:0]       grant_idx;
  logic [PW:0]         search_sum;
  logic [PW-1:0]       search_idx;
  logic                link_vc;

  assign link_vc = ~polarity;

  generate
    for (genvar i = 0; i < NREQ; i++) begin : g_req
      assign data_slice[i] = data_in[i*DW +: DW];
      assign elig[i] = req[i] & (data_in[i*DW + DW - 1] == polarity)
                     & ~full_q[polarity] & ~reset;
    end
  endgenerate

  // Round-robin search starting at the pointer of the internal-phase VC.
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    search_sum  = '0;
    search_idx  = '0;
    for (int off = 0; off < NREQ; off++) begin
      search_sum = {1'b0, ptr_q[polarity]} + (PW+1)'(off);
      if (search_sum >= (PW+1)'(NREQ)) begin
        search_sum = search_sum - (PW+1)'(NREQ);
      end
      search_idx = search_sum[PW-1:0];
      if (!grant_valid && elig[search_idx]) begin
        grant_valid = 1'b1;
        grant_idx   = search_idx;
      end
    end
    gnt = grant_valid ? (NREQ'(1) << grant_idx) : '0;
  end

  assign so   = ri & full_q[link_vc] & ~reset;
  assign dout = so ? buf_q[link_vc] : '0;
  assign pkt_count = cnt_q;

  // Load and send always target different VCs, so both may apply at once.
  always_comb begin
    full_d = full_q;
    buf_d  = buf_q;
    ptr_d  = ptr_q;
    cnt_d  = cnt_q;
    if (grant_valid) begin
      full_d[polarity] = 1'b1;
      buf_d[polarity]  = data_slice[grant_idx];
      ptr_d[polarity]  = (grant_idx == PW'(NREQ - 1)) ? '0 : grant_idx + PW'(1);
    end
    if (so) begin
      full_d[link_vc] = 1'b0;
      cnt_d           = cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      full_q   <= '0;
      buf_q[0] <= '0;
      buf_q[1] <= '0;
      ptr_q[0] <= '0;
      ptr_q[1] <= '0;
      cnt_q    <= '0;
    end else begin
      full_q   <= full_d;
      buf_q[0] <= buf_d[0];
      buf_q[1] <= buf_d[1];
      ptr_q[0] <= ptr_d[0];
      ptr_q[1] <= ptr_d[1];
      cnt_q    <= cnt_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_noc_output_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_noc_output_arbiter
// Description : Directed self-checking bench for noc_output_arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_noc_output_arbiter;

  logic         clk;
  logic         reset;
  logic         polarity;
  logic [4:0]   req;
  logic [319:0] data_in;
  logic [4:0]   gnt;
  logic         ri;
  logic         so;
  logic [63:0]  dout;
  logic [15:0]  pkt_count;
  logic [63:0]  d [5];

  int total = 0;
  int bad   = 0;

  assign data_in = {d[4], d[3], d[2], d[1], d[0]};

  noc_output_arbiter #(.NREQ(5), .DW(64)) dut (
    .clk       (clk),
    .reset     (reset),
    .polarity  (polarity),
    .req       (req),
    .data_in   (data_in),
    .gnt       (gnt),
    .ri        (ri),
    .so        (so),
    .dout      (dout),
    .pkt_count (pkt_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Inputs change on the falling edge; outputs are sampled 1 ns later.
  task automatic drive(input logic p, input logic [4:0] rq, input logic r_i, input logic rs);
    @(negedge clk);
    polarity = p;
    req      = rq;
    ri       = r_i;
    reset    = rs;
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    reset = 1'b1; polarity = 1'b0; req = '0; ri = 1'b0;
    for (int i = 0; i < 5; i++) d[i] = 64'h100 + 64'(i);

    // Reset held two cycles with all requesters active
    drive(1'b0, 5'b11111, 1'b1, 1'b1);
    chk("rst_gnt0", gnt, 0); chk("rst_so0", so, 0); chk("rst_do0", dout, 0);
    drive(1'b1, 5'b11111, 1'b1, 1'b1);
    chk("rst_gnt1", gnt, 0); chk("rst_so1", so, 0); chk("rst_do1", dout, 0);
    chk("rst_cnt", pkt_count, 0);

    // Single packet
    d[0] = 64'h0000_0000_0000_00AA;
    drive(1'b0, 5'b00001, 1'b1, 1'b0);
    chk("single_gnt", gnt, 5'b00001); chk("single_so_pre", so, 0);
    drive(1'b1, 5'b00000, 1'b1, 1'b0);
    chk("single_so", so, 1); chk("single_do", dout, 64'hAA); chk("single_gnt_vc1", gnt, 0);
    drive(1'b0, 5'b00000, 1'b1, 1'b0);
    chk("single_cnt", pkt_count, 1); chk("single_so_after", so, 0);

    // Round robin from reset
    for (int i = 0; i < 5; i++) d[i] = 64'h100 + 64'(i);
    drive(1'b0, 5'b00000, 1'b1, 1'b1);
    for (int i = 0; i < 6; i++) begin
      drive(1'b0, 5'b11111, 1'b1, 1'b0);
      chk($sformatf("rr_gnt%0d", i), gnt, 64'(5'b00001 << (i % 5)));
      drive(1'b1, 5'b11111, 1'b1, 1'b0);
      chk($sformatf("rr_so%0d", i), so, 1);
      chk($sformatf("rr_do%0d", i), dout, d[i % 5]);
      chk($sformatf("rr_gnt_vc1_%0d", i), gnt, 0);
    end
    drive(1'b0, 5'b00000, 1'b1, 1'b0);
    chk("rr_cnt", pkt_count, 6);

    // Backpressure: pointer for VC0 is now 1, only requester 0 active
    d[0] = 64'h0000_0000_0000_BEEF;
    drive(1'b0, 5'b00001, 1'b0, 1'b0);
    chk("bp_gnt_first", gnt, 5'b00001);
    drive(1'b1, 5'b00001, 1'b0, 1'b0);
    chk("bp_so_held", so, 0); chk("bp_do_held", dout, 0);
    drive(1'b0, 5'b00001, 1'b0, 1'b0);
    chk("bp_gnt_blocked", gnt, 0);
    drive(1'b1, 5'b00001, 1'b1, 1'b0);
    chk("bp_so_release", so, 1); chk("bp_do_release", dout, 64'hBEEF);
    drive(1'b0, 5'b00001, 1'b1, 1'b0);
    chk("bp_gnt_after", gnt, 5'b00001); chk("bp_cnt", pkt_count, 7);
    drive(1'b1, 5'b00000, 1'b1, 1'b0);
    chk("bp_so_drain", so, 1); chk("bp_do_drain", dout, 64'hBEEF);

    // VC mismatch: requester 2 carries a VC1 packet
    d[2] = 64'h8000_0000_0000_0022;
    drive(1'b0, 5'b00100, 1'b1, 1'b0);
    chk("vc_gnt_pol0", gnt, 0); chk("vc_cnt", pkt_count, 8);
    drive(1'b1, 5'b00100, 1'b1, 1'b0);
    chk("vc_gnt_pol1", gnt, 5'b00100);
    drive(1'b0, 5'b00000, 1'b1, 1'b0);
    chk("vc_so", so, 1); chk("vc_do", dout, 64'h8000_0000_0000_0022);
    drive(1'b1, 5'b00000, 1'b1, 1'b0);
    chk("vc_cnt_after", pkt_count, 9);

    // Reset mid-operation with both buffers full
    d[0] = 64'h0000_0000_0000_0055;
    d[1] = 64'h8000_0000_0000_0011;
    drive(1'b0, 5'b00011, 1'b0, 1'b0);
    chk("mid_gnt_vc0", gnt, 5'b00001);
    drive(1'b1, 5'b00011, 1'b0, 1'b0);
    chk("mid_gnt_vc1", gnt, 5'b00010); chk("mid_so_bp", so, 0);
    drive(1'b0, 5'b00000, 1'b1, 1'b1);
    chk("mid_so_rst", so, 0); chk("mid_do_rst", dout, 0);
    drive(1'b1, 5'b00000, 1'b1, 1'b0);
    chk("mid_so_vc0", so, 0); chk("mid_do_vc0", dout, 0);
    drive(1'b0, 5'b00011, 1'b1, 1'b0);
    chk("mid_so_vc1", so, 0); chk("mid_do_vc1", dout, 0);
    chk("mid_cnt", pkt_count, 0); chk("mid_gnt_first_vc0", gnt, 5'b00001);
    drive(1'b1, 5'b00011, 1'b1, 1'b0);
    chk("mid_gnt_first_vc1", gnt, 5'b00010);
    chk("mid_so_new", so, 1); chk("mid_do_new", dout, 64'h55);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
